// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first, configurable data/parity/stop.
// Latency: a byte written into an empty FIFO while idle starts its start bit on the next edge.
// Backpressure: full is decoded from registered level; writes while full are dropped and flagged by overrun.
// Optional feature: define UART_TX_BREAK_EN to add the brk line-break input.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        din,
  input  logic                              wr_en,
`ifdef UART_TX_BREAK_EN
  input  logic                              brk,
`endif
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overrun,
  output logic                              tx_busy,
  output logic                              tx_p
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    DMASK    = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK, S_MAB
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_par;
  logic          r_tx;
  logic          r_busy;

  logic          w_tick;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_stop_end;
  logic          w_slot;
  logic          w_brk;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_head_par;

  assign w_tick     = (r_cnt == CNT_MAX);
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_push     = wr_en && !w_full;
  assign w_stop_end = (r_state == S_STOP) && w_tick && (r_idx == 3'(STOP_BITS - 1));
  assign w_head     = r_mem[r_rptr];
  // Even parity is the XOR of the transmitted data bits; odd is its inverse.
  assign w_head_par = (PARITY == 1) ? ~(^(w_head & DMASK)) : ^(w_head & DMASK);

`ifdef UART_TX_BREAK_EN
  // A pending break blocks pops; the end of mark-after-break is also a pop slot.
  assign w_brk  = brk;
  assign w_slot = (r_state == S_IDLE) || w_stop_end || ((r_state == S_MAB) && w_tick);
`else
  assign w_brk  = 1'b0;
  assign w_slot = (r_state == S_IDLE) || w_stop_end;
`endif

  assign w_pop = w_slot && !w_empty && !w_brk;

  assign full    = w_full;
  assign level   = r_level;
  assign overrun = r_overrun;
  assign tx_busy = r_busy;
  assign tx_p    = r_tx;

  // FIFO storage: no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // FIFO pointers, occupancy and the overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= wr_en && w_full;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Frame FSM: bit timer restarts on every pop so each bit lasts exactly DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_BRK) || w_tick) r_cnt <= '0;
      else                                                     r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_brk) begin
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_BRK;
          end else if (w_pop) begin
            r_sh    <= w_head;
            r_par   <= w_head_par;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: if (w_tick) begin
          r_tx    <= r_sh[0];
          r_state <= S_DATA;
        end
        S_DATA: if (w_tick) begin
          if (r_idx != 3'(DATA_BITS - 1)) begin
            r_sh  <= r_sh >> 1;
            r_tx  <= r_sh[1];
            r_idx <= r_idx + 1'b1;
          end else if (PARITY != 0) begin
            r_tx    <= r_par;
            r_state <= S_PAR;
          end else begin
            r_tx    <= 1'b1;
            r_idx   <= '0;
            r_state <= S_STOP;
          end
        end
        S_PAR: if (w_tick) begin
          r_tx    <= 1'b1;
          r_idx   <= '0;
          r_state <= S_STOP;
        end
        S_STOP: if (w_tick) begin
          if (!w_stop_end) begin
            r_idx <= r_idx + 1'b1;
          end else if (w_pop) begin
            r_sh    <= w_head;
            r_par   <= w_head_par;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BRK: if (!brk) begin
          r_tx    <= 1'b1;
          r_state <= S_MAB;
        end
        S_MAB: if (w_tick) begin
          if (w_pop) begin
            r_sh    <= w_head;
            r_par   <= w_head_par;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
